// File: rtl/ps2_key_controller.sv
// PS/2 scan-code parser: turns keyboard_decoder bytes into W/A/S/D and arrow direction state
// and queues press/release events in a first-word-fall-through FIFO.
module ps2_key_controller #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] word,
    input  logic       read,
    input  logic       evt_pop,
    output logic [2:0] evt_data,
    output logic       evt_valid,
    output logic [3:0] held,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    // {hit, dir[1:0]} decoders for the two key groups
    function automatic logic [2:0] f_wasd(input logic [7:0] b);
        case (b)
            8'h1D:   return 3'b100;
            8'h1C:   return 3'b101;
            8'h1B:   return 3'b110;
            8'h23:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] f_arrow(input logic [7:0] b);
        case (b)
            8'h75:   return 3'b100;
            8'h6B:   return 3'b101;
            8'h72:   return 3'b110;
            8'h74:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    logic            r_read_s1, r_read_s2, r_read_d;
    logic            r_byte_vld;
    logic [7:0]      r_word;
    logic            w_accept;
    state_t          r_state, w_state_nxt;
    logic [TW-1:0]   r_tmo_cnt;
    logic            w_timeout;
    logic            w_make, w_brk;
    logic [1:0]      w_key;
    logic [2:0]      w_wasd, w_arrow;
    logic            w_do_make, w_do_brk, w_push, w_pop, w_wr, w_full, w_empty;
    logic [2:0]      w_push_data;
    logic [3:0]      w_held_rem;
    logic [3:0]      r_held;
    logic [1:0]      r_dir;
    logic            r_dir_valid, r_ovf;
    logic [2:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;

    // Stage p0: synchronise read, detect its rising edge, capture the byte
    assign w_accept = r_read_s2 & ~r_read_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_s1  <= 1'b0;
            r_read_s2  <= 1'b0;
            r_read_d   <= 1'b0;
            r_byte_vld <= 1'b0;
            r_word     <= 8'h00;
        end else begin
            r_read_s1  <= read;
            r_read_s2  <= r_read_s1;
            r_read_d   <= r_read_s2;
            r_byte_vld <= w_accept;
            if (w_accept)
                r_word <= word;
        end
    end

    // Stage p1: prefix FSM with abort timer
    assign w_timeout = (r_state != S_IDLE) && (r_tmo_cnt == TMO_LAST);
    assign w_wasd    = f_wasd(r_word);
    assign w_arrow   = f_arrow(r_word);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept || r_state == S_IDLE || w_timeout)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_key       = 2'd0;
        if (r_byte_vld) begin
            case (r_state)
                S_IDLE: begin
                    if (r_word == 8'hF0)      w_state_nxt = S_BRK;
                    else if (r_word == 8'hE0) w_state_nxt = S_EXT;
                    else if (w_wasd[2]) begin
                        w_make = 1'b1;
                        w_key  = w_wasd[1:0];
                    end
                end
                S_EXT: begin
                    if (r_word == 8'hF0)      w_state_nxt = S_EXT_BRK;
                    else if (r_word == 8'hE0) w_state_nxt = S_EXT;
                    else begin
                        w_state_nxt = S_IDLE;
                        w_make      = w_arrow[2];
                        w_key       = w_arrow[1:0];
                    end
                end
                S_BRK: begin
                    if (r_word == 8'hF0) w_state_nxt = S_BRK;
                    else begin
                        w_state_nxt = S_IDLE;
                        w_brk       = w_wasd[2];
                        w_key       = w_wasd[1:0];
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_brk       = w_arrow[2];
                    w_key       = w_arrow[1:0];
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Stage p2: held/direction state and event FIFO
    assign w_do_make   = w_make & ~r_held[w_key];
    assign w_do_brk    = w_brk & r_held[w_key];
    assign w_push      = w_do_make | w_do_brk;
    assign w_push_data = {w_do_make, w_key};
    assign w_held_rem  = r_held & ~(4'b0001 << w_key);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pop       = evt_pop & ~w_empty;
    assign w_wr        = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held      <= 4'b0000;
            r_dir       <= 2'd0;
            r_dir_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_do_make) begin
                r_held[w_key] <= 1'b1;
                r_dir         <= w_key;
                r_dir_valid   <= 1'b1;
            end else if (w_do_brk) begin
                r_held <= w_held_rem;
                if (w_held_rem == 4'b0000)
                    r_dir_valid <= 1'b0;
                else if (w_key == r_dir)
                    r_dir <= f_lowest(w_held_rem);
            end
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    assign evt_data  = w_empty ? 3'b000 : r_mem[r_rd_ptr];
    assign evt_valid = ~w_empty;
    assign held      = r_held;
    assign dir       = r_dir;
    assign dir_valid = r_dir_valid;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Scoreboard bench for ps2_key_controller: stimulus pushes expected events, a monitor pops and compares.
module tb_ps2_key_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] word = 8'h00;
    logic       read = 1'b0;
    logic       evt_pop;
    logic       mon_pop = 1'b0;
    logic       man_pop = 1'b0;
    logic       pop_en = 1'b0;
    logic [2:0] evt_data;
    logic       evt_valid;
    logic [3:0] held;
    logic [1:0] dir;
    logic       dir_valid;
    logic       overflow;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;

    assign evt_pop = mon_pop | man_pop;

    ps2_key_controller #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .word(word), .read(read), .evt_pop(evt_pop),
        .evt_data(evt_data), .evt_valid(evt_valid), .held(held), .dir(dir),
        .dir_valid(dir_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic send_hold(input logic [7:0] b, input int hi_cycles);
        @(posedge clk); #1;
        word = b;
        read = 1'b1;
        repeat (hi_cycles) @(posedge clk);
        #1 read = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        send_hold(b, 6);
    endtask

    // Monitor: compare and pop the head whenever an event is presented
    always @(negedge clk) begin
        mon_pop = 1'b0;
        if (pop_en && evt_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL evt_unexpected: got %b required none", evt_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (evt_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL evt_data: got %b required %b", evt_data, mon_exp);
                end
            end
            mon_pop = 1'b1;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_held", {4'b0, held}, 8'h00);
        check("rst_dir", {6'b0, dir}, 8'h00);
        check("rst_dir_valid", {7'b0, dir_valid}, 8'h00);
        check("rst_evt_valid", {7'b0, evt_valid}, 8'h00);
        check("rst_evt_data", {5'b0, evt_data}, 8'h00);
        check("rst_overflow", {7'b0, overflow}, 8'h00);
        reset = 1'b0;
        pop_en = 1'b1;

        // make A
        exp_q.push_back(3'b101);
        send(8'h1C);
        check("makeA_held", {4'b0, held}, 8'b0010);
        check("makeA_dir", {6'b0, dir}, 8'd1);
        check("makeA_dir_valid", {7'b0, dir_valid}, 8'd1);

        // break A
        exp_q.push_back(3'b001);
        send(8'hF0);
        send(8'h1C);
        check("brkA_held", {4'b0, held}, 8'b0000);
        check("brkA_dir_valid", {7'b0, dir_valid}, 8'd0);
        check("brkA_dir", {6'b0, dir}, 8'd1);

        // up arrow, then S
        exp_q.push_back(3'b100);
        send(8'hE0);
        send(8'h75);
        check("up_held", {4'b0, held}, 8'b0001);
        exp_q.push_back(3'b110);
        send(8'h1B);
        check("S_held", {4'b0, held}, 8'b0101);
        check("S_dir", {6'b0, dir}, 8'd2);

        // release of left arrow that is not held: ignored
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        check("brk_unheld_held", {4'b0, held}, 8'b0101);
        check("brk_unheld_dir", {6'b0, dir}, 8'd2);

        // release S: dir falls back to lowest remaining (up)
        exp_q.push_back(3'b010);
        send(8'hF0);
        send(8'h1B);
        check("brkS_held", {4'b0, held}, 8'b0001);
        check("brkS_dir", {6'b0, dir}, 8'd0);
        check("brkS_dir_valid", {7'b0, dir_valid}, 8'd1);
        check("q_drained_1", 8'(exp_q.size()), 8'd0);

        // asynchronous reset between edges
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("arst_held", {4'b0, held}, 8'h00);
        check("arst_dir_valid", {7'b0, dir_valid}, 8'h00);
        check("arst_evt_valid", {7'b0, evt_valid}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;

        // typematic repeat and stray byte
        exp_q.push_back(3'b100);
        send(8'h1D);
        send(8'h1D);
        send(8'h1D);
        send(8'h15);
        check("rep_held", {4'b0, held}, 8'b0001);
        check("rep_dir", {6'b0, dir}, 8'd0);

        // long read pulse must be one accept (a second 1D would re-press up)
        exp_q.push_back(3'b000);
        send(8'hF0);
        send_hold(8'h1D, 50);
        check("long_held", {4'b0, held}, 8'b0000);
        check("long_dir_valid", {7'b0, dir_valid}, 8'd0);
        check("q_drained_2", 8'(exp_q.size()), 8'd0);

        // overflow: four makes fill the FIFO, fifth event dropped
        pop_en = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b111);
        send(8'h1D);
        send(8'h1C);
        send(8'h1B);
        send(8'h23);
        check("full_overflow_pre", {7'b0, overflow}, 8'd0);
        send(8'hF0);
        send(8'h1D);
        check("ovf_overflow", {7'b0, overflow}, 8'd1);
        check("ovf_evt_valid", {7'b0, evt_valid}, 8'd1);
        check("ovf_held", {4'b0, held}, 8'b1110);
        check("ovf_dir", {6'b0, dir}, 8'd3);

        // push and pop on the same edge while full
        send(8'hF0);
        @(posedge clk); #1;
        word = 8'h1C;
        read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_exp = exp_q.pop_front();
        check("fullpop_head", {5'b0, evt_data}, {5'b0, mon_exp});
        exp_q.push_back(3'b001);
        man_pop = 1'b1;
        @(posedge clk); #1;
        man_pop = 1'b0;
        repeat (2) @(posedge clk);
        #1 read = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("fullpop_overflow", {7'b0, overflow}, 8'd1);
        check("fullpop_held", {4'b0, held}, 8'b1100);
        check("fullpop_evt_valid", {7'b0, evt_valid}, 8'd1);

        pop_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_evt_valid", {7'b0, evt_valid}, 8'd0);
        check("q_drained_3", 8'(exp_q.size()), 8'd0);

        // timeout: stale F0 must not turn the next 1C into a release
        send(8'hF0);
        repeat (20) @(posedge clk);
        exp_q.push_back(3'b101);
        send(8'h1C);
        check("tmo_held", {4'b0, held}, 8'b1110);
        check("tmo_dir", {6'b0, dir}, 8'd1);

        for (int i = 0; i < 50 && (exp_q.size() != 0 || evt_valid); i++)
            @(posedge clk);
        #1;
        check("final_q_empty", 8'(exp_q.size()), 8'd0);
        check("final_evt_valid", {7'b0, evt_valid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
